gpr_wb_arbiter: RTL and testbench
=================================

Name: gpr_wb_arbiter

Overview:
- Write-side front end for the 32x32 GPR file's single write port (clocked on negedge clk).
- Merges the in-order ALU/load writeback stream with results from the multi-cycle mult/div unit.
- Long-latency results queue in a small FIFO and drain into idle write slots.
- Exports a busy mask so decode can stall on pending destinations; a starvation counter forces a drain slot when the ALU stream never idles.

Parameters:
- DEPTH, 2, mult/div FIFO entries; power of 2, minimum 2.
- STARVE_LIMIT, 4, cycles a FIFO head may wait before an ALU stall slot is forced; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- alu_we  input  1  ALU/load writeback request this cycle.
- alu_rd  input  5  ALU destination register.
- alu_wd  input  32  ALU write data.
- md_valid  input  1  mult/div result offered.
- md_rd  input  5  mult/div destination register.
- md_wd  input  32  mult/div result data.
- md_ready  output  1  FIFO can accept; md transfer occurs on posedge when md_valid and md_ready are both 1.
- alu_stall  output  1  forced drain slot; ALU request is not accepted and upstream must hold it.
- we  output  1  GPR write enable (registered).
- rd  output  5  GPR write address (registered).
- wd  output  32  GPR write data (registered).
- busy_mask  output  32  bit n set while a live FIFO entry targets register n.

Behaviour:
- Reset (async): FIFO empty, all kill bits clear, starve_cnt=0, we=0, rd=0, wd=0. Therefore md_ready=1, alu_stall=0, busy_mask=0. Reset mid-drain discards queued entries.
- Grant priority each posedge:
  1. If alu_stall=1 and FIFO non-empty: grant FIFO head.
  2. Else if alu_we: grant ALU.
  3. Else if FIFO non-empty: grant FIFO head.
  4. Else: no grant.
- Output register:
  - we <= grant valid, source rd != 0, and (source is ALU or head kill bit = 0).
  - rd/wd <= granted source; they hold their last value when we=0.
- Latency: the request presented before posedge N appears on we/rd/wd during cycle N+1 and is written at the negedge inside cycle N+1.
- md path:
  - md_ready = !full. It does not look ahead to a same-cycle pop.
  - Accepted result with md_rd=0 is consumed and dropped, never enqueued.
  - Push and pop in the same cycle are legal whenever md_ready=1; count is unchanged.
- Ordering/WAW:
  - When ALU is granted with alu_rd matching any live FIFO entry, each matching entry's kill bit is set.
  - A killed entry still pops in order but produces we=0.
  - busy_mask excludes killed entries.
  - ALU write with alu_rd=0 kills nothing.
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and the head does not pop; it saturates at STARVE_LIMIT.
  - Clears on pop, or when the FIFO is empty.
  - alu_stall = (starve_cnt == STARVE_LIMIT), a combinational decode of registered state.
- Pointers: wrap modulo DEPTH; count is 0..DEPTH.
- busy_mask: OR over live, unkilled entries of the one-hot decode of the entry rd.

Decomposition:
- Shared package cpu_pkg:
  - GPR_AW=5, GPR_DW=32.
  - wb_entry_t struct {rd, wd, kill}.
  - Grant-source enum {GNT_NONE, GNT_ALU, GNT_MD}.
- Sub-module wb_fifo:
  - Parameterised circular buffer exposing full/empty/head.
  - Per-entry kill-by-match input.
  - Live-entry rd vector for busy_mask.

Test Plan:
- Reset then alu_we=1, alu_rd=5, alu_wd=0x1234 -> next cycle we=1, rd=5, wd=0x1234; GPR[5]=0x1234 after negedge.
- With ALU idle, md_valid pulse rd=9, wd=0xDEADBEEF -> busy_mask=0x200 for one cycle, then we=1, rd=9; busy_mask returns to 0.
- alu_we held high continuously and one md entry (rd=3) queued -> alu_stall=1 exactly STARVE_LIMIT(4) cycles after enqueue; that slot writes rd=3; alu_stall drops next cycle and the ALU stream resumes without losing the held request.
- With alu_we held, push 2 md entries -> md_ready=0 while full; a third md_valid is not accepted until a drain slot pops.
- Enqueue md rd=7, then ALU write rd=7 before drain -> busy_mask bit 7 clears; the later md pop gives we=0; GPR[7] holds the ALU value.
- md_rd=0 accepted -> no enqueue, busy_mask=0, no write. Assert rst while 2 entries are queued -> we=0, md_ready=1, busy_mask=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared GPR write-path types: entry layout and grant source encoding.
package cpu_pkg;

  localparam int unsigned GPR_AW = 5;
  localparam int unsigned GPR_DW = 32;

  typedef struct packed {
    logic [GPR_AW-1:0] rd;
    logic [GPR_DW-1:0] wd;
    logic              kill;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_MD
  } gnt_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending mult/div writebacks with per-entry kill-by-destination.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [GPR_AW-1:0]        i_push_rd,
  input  logic [GPR_DW-1:0]        i_push_wd,
  input  logic                     i_pop,
  input  logic                     i_kill_en,
  input  logic [GPR_AW-1:0]        i_kill_rd,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [GPR_AW-1:0]        o_head_rd,
  output logic [GPR_DW-1:0]        o_head_wd,
  output logic                     o_head_kill,
  output logic [DEPTH*GPR_AW-1:0]  o_live_rd,
  output logic [DEPTH-1:0]         o_live_vld
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;

  // Per-slot valid bits make full/empty a direct lookup at the pointers.
  assign o_full      = r_vld[r_wptr];
  assign o_empty     = !r_vld[r_rptr];
  assign o_head_rd   = r_mem[r_rptr].rd;
  assign o_head_wd   = r_mem[r_rptr].wd;
  assign o_head_kill = r_mem[r_rptr].kill;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Only entries already queued are older than the ALU write; a same-cycle push is newer.
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_en && r_vld[i] && (r_mem[i].rd == i_kill_rd)) begin
          r_mem[i].kill <= 1'b1;
        end
      end
      if (i_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + 1'b1;
      end
      if (i_push) begin
        r_mem[r_wptr] <= '{rd: i_push_rd, wd: i_push_wd, kill: 1'b0};
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + 1'b1;
      end
    end
  end

  always_comb begin
    o_live_rd  = '0;
    o_live_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_live_rd[i*GPR_AW +: GPR_AW] = r_mem[i].rd;
      o_live_vld[i]                 = r_vld[i] & ~r_mem[i].kill;
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates the GPR write port between the ALU stream and queued mult/div results,
// with WAW kill, destination busy mask and a starvation-forced drain slot.
module gpr_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_we,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_wd,
  input  logic        i_md_valid,
  input  logic [4:0]  i_md_rd,
  input  logic [31:0] i_md_wd,
  output logic        o_md_ready,
  output logic        o_alu_stall,
  output logic        o_we,
  output logic [4:0]  o_rd,
  output logic [31:0] o_wd,
  output logic [31:0] o_busy_mask
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]           r_starve;
  gnt_src_e                w_gnt;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_kill_en;
  logic                    w_we_d;
  logic [GPR_AW-1:0]       w_head_rd;
  logic [GPR_DW-1:0]       w_head_wd;
  logic                    w_head_kill;
  logic [GPR_AW-1:0]       w_src_rd;
  logic [GPR_DW-1:0]       w_src_wd;
  logic [DEPTH*GPR_AW-1:0] w_live_rd;
  logic [DEPTH-1:0]        w_live_vld;

  assign o_alu_stall = (r_starve == SW'(STARVE_LIMIT));
  assign o_md_ready  = !w_full;
  // rd=0 results are accepted but dropped here.
  assign w_push      = i_md_valid && !w_full && (i_md_rd != '0);
  assign w_pop       = (w_gnt == GNT_MD);
  assign w_kill_en   = (w_gnt == GNT_ALU) && (i_alu_rd != '0);

  always_comb begin
    if (o_alu_stall && !w_empty) begin
      w_gnt = GNT_MD;
    end else if (i_alu_we) begin
      w_gnt = GNT_ALU;
    end else if (!w_empty) begin
      w_gnt = GNT_MD;
    end else begin
      w_gnt = GNT_NONE;
    end
  end

  always_comb begin
    w_src_rd = i_alu_rd;
    w_src_wd = i_alu_wd;
    w_we_d   = 1'b0;
    unique case (w_gnt)
      GNT_ALU: w_we_d = (i_alu_rd != '0);
      GNT_MD: begin
        w_src_rd = w_head_rd;
        w_src_wd = w_head_wd;
        w_we_d   = (w_head_rd != '0) && !w_head_kill;
      end
      default: w_we_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_we     <= 1'b0;
      o_rd     <= '0;
      o_wd     <= '0;
      r_starve <= '0;
    end else begin
      o_we <= w_we_d;
      if (w_we_d) begin
        o_rd <= w_src_rd;
        o_wd <= w_src_wd;
      end
      if (w_empty || w_pop) begin
        r_starve <= '0;
      end else if (!o_alu_stall) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  always_comb begin
    o_busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live_vld[i]) begin
        o_busy_mask[w_live_rd[i*GPR_AW +: GPR_AW]] = 1'b1;
      end
    end
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_push),
    .i_push_rd  (i_md_rd),
    .i_push_wd  (i_md_wd),
    .i_pop      (w_pop),
    .i_kill_en  (w_kill_en),
    .i_kill_rd  (i_alu_rd),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_rd  (w_head_rd),
    .o_head_wd  (w_head_wd),
    .o_head_kill(w_head_kill),
    .o_live_rd  (w_live_rd),
    .o_live_vld (w_live_vld)
  );

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios plus random traffic against a queue model.
module tb_gpr_wb_arbiter;

  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_we = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_wd = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_wd = '0;
  logic        md_ready;
  logic        alu_stall;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [31:0] busy_mask;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] gpr [32];

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
    bit          kill;
  } ment_t;

  ment_t       mq[$];
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_wd = '0;

  gpr_wb_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_alu_we   (alu_we),
    .i_alu_rd   (alu_rd),
    .i_alu_wd   (alu_wd),
    .i_md_valid (md_valid),
    .i_md_rd    (md_rd),
    .i_md_wd    (md_wd),
    .o_md_ready (md_ready),
    .o_alu_stall(alu_stall),
    .o_we       (we),
    .o_rd       (rd),
    .o_wd       (wd),
    .o_busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  // GPR file writes on the falling edge.
  always @(negedge clk) begin
    if (we) gpr[rd] <= wd;
  end

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_we = 1'b0;
    m_rd = '0;
    m_wd = '0;
  endtask

  // Advance the reference model by one cycle from the current inputs, then clock the DUT.
  task automatic tick();
    int    n;
    int    g;
    bit    popped;
    ment_t h;
    n = mq.size();
    popped = 0;
    if (m_starve == STARVE && n > 0) g = 2;
    else if (alu_we) g = 1;
    else if (n > 0) g = 2;
    else g = 0;
    m_we = 1'b0;
    if (g == 1) begin
      if (alu_rd != 0) begin
        m_we = 1'b1; m_rd = alu_rd; m_wd = alu_wd;
        for (int i = 0; i < mq.size(); i++) if (mq[i].rd == alu_rd) mq[i].kill = 1;
      end
    end else if (g == 2) begin
      h = mq.pop_front();
      popped = 1;
      if (h.rd != 0 && !h.kill) begin
        m_we = 1'b1; m_rd = h.rd; m_wd = h.wd;
      end
    end
    if (n == 0 || popped) m_starve = 0;
    else if (m_starve < STARVE) m_starve = m_starve + 1;
    if (md_valid && n < DEPTH && md_rd != 0) begin
      h.rd = md_rd; h.wd = md_wd; h.kill = 0;
      mq.push_back(h);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (mq[i]) if (!mq[i].kill) b[mq[i].rd] = 1'b1;
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", we); end
    n_checks++; if (rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", rd); end
    n_checks++; if (wd !== 32'd0) begin n_fail++; $display("FAIL reset_wd: got %h expected 0", wd); end
    n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL reset_md_ready: got %b expected 1", md_ready); end
    n_checks++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", alu_stall); end
    n_checks++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", busy_mask); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_alu_write();
    alu_we = 1'b1; alu_rd = 5'd5; alu_wd = 32'h1234;
    tick();
    alu_we = 1'b0;
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b expected 1", we); end
    n_checks++; if (rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d expected 5", rd); end
    n_checks++; if (wd !== 32'h1234) begin n_fail++; $display("FAIL alu_wd: got %h expected 1234", wd); end
    @(negedge clk);
    #1;
    n_checks++; if (gpr[5] !== 32'h1234) begin n_fail++; $display("FAIL alu_gpr5: got %h expected 1234", gpr[5]); end
  endtask

  task automatic test_md_single();
    md_valid = 1'b1; md_rd = 5'd9; md_wd = 32'hDEADBEEF;
    tick();
    md_valid = 1'b0;
    n_checks++; if (busy_mask !== 32'h200) begin n_fail++; $display("FAIL md_busy: got %h expected 200", busy_mask); end
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL md_we_idle: got %b expected 0", we); end
    tick();
    n_checks++; if (we !== 1'b1 || rd !== 5'd9 || wd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL md_drain: got we=%b rd=%0d wd=%h expected we=1 rd=9 wd=deadbeef", we, rd, wd);
    end
    n_checks++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL md_busy_clear: got %h expected 0", busy_mask); end
  endtask

  task automatic test_starve();
    int k;
    alu_we = 1'b1; alu_rd = 5'd10; alu_wd = 32'hA0A0;
    md_valid = 1'b1; md_rd = 5'd3; md_wd = 32'h3333;
    tick();
    md_valid = 1'b0;
    k = 0;
    while (!alu_stall && k < 20) begin tick(); k++; end
    n_checks++; if (k !== STARVE) begin n_fail++; $display("FAIL starve_latency: got %0d expected %0d", k, STARVE); end
    tick();
    n_checks++; if (we !== 1'b1 || rd !== 5'd3 || wd !== 32'h3333) begin
      n_fail++; $display("FAIL starve_slot: got we=%b rd=%0d wd=%h expected we=1 rd=3 wd=3333", we, rd, wd);
    end
    n_checks++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %b expected 0", alu_stall); end
    tick();
    n_checks++; if (we !== 1'b1 || rd !== 5'd10 || wd !== 32'hA0A0) begin
      n_fail++; $display("FAIL starve_resume: got we=%b rd=%0d wd=%h expected we=1 rd=10 wd=a0a0", we, rd, wd);
    end
    alu_we = 1'b0;
    tick();
  endtask

  task automatic test_full();
    int k;
    alu_we = 1'b1; alu_rd = 5'd11; alu_wd = 32'hB;
    md_valid = 1'b1; md_rd = 5'd4; md_wd = 32'h1;
    tick();
    md_rd = 5'd6; md_wd = 32'h2;
    tick();
    md_rd = 5'd8; md_wd = 32'h3;
    n_checks++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", md_ready); end
    k = 0;
    while (!md_ready && k < 20) begin tick(); k++; end
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL full_wait: got %0d expected 4", k); end
    n_checks++; if (busy_mask !== 32'h40) begin n_fail++; $display("FAIL full_no_third: got %h expected 40", busy_mask); end
    tick();
    md_valid = 1'b0;
    n_checks++; if (busy_mask !== 32'h140) begin n_fail++; $display("FAIL full_third: got %h expected 140", busy_mask); end
    alu_we = 1'b0;
    k = 0;
    while (busy_mask != 0 && k < 10) begin tick(); k++; end
    n_checks++; if (busy_mask !== 32'd0 || md_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_drain: got busy=%h ready=%b expected busy=0 ready=1", busy_mask, md_ready);
    end
    tick();
  endtask

  task automatic test_kill();
    md_valid = 1'b1; md_rd = 5'd7; md_wd = 32'h77;
    tick();
    md_valid = 1'b0;
    alu_we = 1'b1; alu_rd = 5'd7; alu_wd = 32'hA7;
    tick();
    alu_we = 1'b0;
    n_checks++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL kill_busy: got %h expected 0", busy_mask); end
    n_checks++; if (we !== 1'b1 || rd !== 5'd7) begin n_fail++; $display("FAIL kill_alu: got we=%b rd=%0d expected we=1 rd=7", we, rd); end
    tick();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL kill_pop_we: got %b expected 0", we); end
    n_checks++; if (rd !== 5'd7 || wd !== 32'hA7) begin n_fail++; $display("FAIL kill_hold: got rd=%0d wd=%h expected rd=7 wd=a7", rd, wd); end
    @(negedge clk);
    #1;
    n_checks++; if (gpr[7] !== 32'hA7) begin n_fail++; $display("FAIL kill_gpr7: got %h expected a7", gpr[7]); end
  endtask

  task automatic test_rd0_and_reset();
    md_valid = 1'b1; md_rd = 5'd0; md_wd = 32'h5;
    tick();
    md_valid = 1'b0;
    n_checks++; if (busy_mask !== 32'd0 || md_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd0_enq: got busy=%h ready=%b expected busy=0 ready=1", busy_mask, md_ready);
    end
    tick();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL rd0_write: got %b expected 0", we); end
    alu_we = 1'b1; alu_rd = 5'd12; alu_wd = 32'hC;
    md_valid = 1'b1; md_rd = 5'd13; md_wd = 32'hD;
    tick();
    md_rd = 5'd14; md_wd = 32'hE;
    tick();
    md_valid = 1'b0;
    n_checks++; if (busy_mask !== 32'h6000) begin n_fail++; $display("FAIL pre_rst_busy: got %h expected 6000", busy_mask); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we: got %b expected 0", we); end
    n_checks++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 1", md_ready); end
    n_checks++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL mid_rst_busy: got %h expected 0", busy_mask); end
    n_checks++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall: got %b expected 0", alu_stall); end
    alu_we = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [31:0] eb;
    for (int c = 0; c < 300; c++) begin
      alu_we   = ($urandom_range(0, 99) < 60);
      alu_rd   = 5'($urandom_range(0, 7));
      alu_wd   = $urandom;
      md_valid = ($urandom_range(0, 99) < 40);
      md_rd    = 5'($urandom_range(0, 7));
      md_wd    = $urandom;
      tick();
      eb = model_busy();
      n_checks++; if (we !== m_we) begin n_fail++; $display("FAIL rnd_we c=%0d: got %b expected %b", c, we, m_we); end
      n_checks++; if (rd !== m_rd) begin n_fail++; $display("FAIL rnd_rd c=%0d: got %0d expected %0d", c, rd, m_rd); end
      n_checks++; if (wd !== m_wd) begin n_fail++; $display("FAIL rnd_wd c=%0d: got %h expected %h", c, wd, m_wd); end
      n_checks++; if (busy_mask !== eb) begin n_fail++; $display("FAIL rnd_busy c=%0d: got %h expected %h", c, busy_mask, eb); end
      n_checks++; if (md_ready !== (mq.size() < DEPTH)) begin
        n_fail++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, md_ready, mq.size() < DEPTH);
      end
      n_checks++; if (alu_stall !== (m_starve == STARVE)) begin
        n_fail++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, alu_stall, m_starve == STARVE);
      end
    end
    alu_we = 1'b0;
    md_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_md_single();
    test_starve();
    test_full();
    test_kill();
    test_rd0_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
